// File: rtl/data_mem_mmio.sv
// ---------------------------------------------------------------------------
// data_mem_mmio
//
// Data-side memory for the TinyRISC-V core. The core drives a read address
// and a write address/data/byte-enable every cycle. Each address is decoded
// to one of three targets:
//   - the word-addressed data RAM, or
//   - a small MMIO bank (GPIO output register, 64-bit machine timer, and
//     timer compare with a sticky interrupt), or
//   - nothing (unmapped).
// Read data comes back one cycle after the address is presented. When a read
// and a write hit the same word on the same edge, the read returns the old
// value.
//
// Ports
//   clk            core clock
//   rst_n          asynchronous active-low reset
//   ram_rd_addr_i  byte read address
//   ram_wr_addr_i  byte write address
//   ram_wr_data_i  write data, byte lanes already aligned by the core
//   ram_wr_en_i    per-byte write enable (4'b0000 = no write)
//   ram_rd_data_o  read data, valid one cycle after the address
//   gpio_o         GPIO_OUT register
//   timer_irq_o    sticky timer interrupt pending (IRQ_PEND)
//
// MMIO map (byte offset from MMIO_BASE)
//   0x00 GPIO_OUT     0x04 MTIME_LO     0x08 MTIME_HI
//   0x0C MTIMECMP_LO  0x10 MTIMECMP_HI  0x14 CTRL {.., IRQ_PEND(W1C), EN}
// ---------------------------------------------------------------------------
module data_mem_mmio #(
    parameter int unsigned RAM_DEPTH = 4096,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ram_rd_addr_i,
    input  logic [31:0] ram_wr_addr_i,
    input  logic [31:0] ram_wr_data_i,
    input  logic [3:0]  ram_wr_en_i,
    output logic [31:0] ram_rd_data_o,
    output logic [31:0] gpio_o,
    output logic        timer_irq_o
);

    localparam int IDX_W = $clog2(RAM_DEPTH);

    localparam logic [5:0] OFF_GPIO      = 6'd0;
    localparam logic [5:0] OFF_MTIME_LO  = 6'd1;
    localparam logic [5:0] OFF_MTIME_HI  = 6'd2;
    localparam logic [5:0] OFF_MTCMP_LO  = 6'd3;
    localparam logic [5:0] OFF_MTCMP_HI  = 6'd4;
    localparam logic [5:0] OFF_CTRL      = 6'd5;

    // Which source the registered read data comes from.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_MMIO = 2'd2
    } rd_sel_t;

    // Replace the enabled byte lanes of old_word with the matching lanes of data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] data,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = data[8*k +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Address decode (MMIO takes precedence if the two regions overlap)
    // ------------------------------------------------------------------
    logic             rd_mmio, rd_ram, wr_mmio, wr_ram, wr_any;
    logic [5:0]       rd_off, wr_off;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [3:0]       ram_we;

    assign rd_mmio = (ram_rd_addr_i[31:8] == MMIO_BASE[31:8]);
    assign rd_ram  = !rd_mmio && (ram_rd_addr_i[31:28] == RAM_BASE[31:28]);
    assign wr_mmio = (ram_wr_addr_i[31:8] == MMIO_BASE[31:8]);
    assign wr_ram  = !wr_mmio && (ram_wr_addr_i[31:28] == RAM_BASE[31:28]);
    assign wr_any  = |ram_wr_en_i;

    assign rd_off  = ram_rd_addr_i[7:2];
    assign wr_off  = ram_wr_addr_i[7:2];
    assign rd_idx  = ram_rd_addr_i[IDX_W+1:2];
    assign wr_idx  = ram_wr_addr_i[IDX_W+1:2];

    // Low address bits and the bits between the RAM index and the region
    // tag do not select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ram_rd_addr_i, ram_wr_addr_i};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ram_we
            assign ram_we[gi] = wr_ram & ram_wr_en_i[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Data RAM: byte-lane writes, registered read. Non-blocking semantics
    // give read-first behaviour on a same-word collision. Contents and the
    // read register are not reset; the output mux hides ram_q_reg until a
    // RAM read has actually been issued after reset.
    // ------------------------------------------------------------------
    logic [31:0] mem [RAM_DEPTH];
    logic [31:0] ram_q_reg;

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ram_we[k]) begin
                mem[wr_idx][8*k +: 8] <= ram_wr_data_i[8*k +: 8];
            end
        end
        ram_q_reg <= mem[rd_idx];
    end

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    logic [31:0] gpio_reg, gpio_next;
    logic [63:0] mtime_reg, mtime_next;
    logic [63:0] mtcmp_reg, mtcmp_next;
    logic        en_reg, en_next;
    logic        irq_reg, irq_next;

    logic gpio_wr, mtime_lo_wr, mtime_hi_wr, mtcmp_lo_wr, mtcmp_hi_wr, ctrl_wr;
    logic irq_set, irq_clr;

    assign gpio_wr     = wr_mmio && wr_any && (wr_off == OFF_GPIO);
    assign mtime_lo_wr = wr_mmio && wr_any && (wr_off == OFF_MTIME_LO);
    assign mtime_hi_wr = wr_mmio && wr_any && (wr_off == OFF_MTIME_HI);
    assign mtcmp_lo_wr = wr_mmio && wr_any && (wr_off == OFF_MTCMP_LO);
    assign mtcmp_hi_wr = wr_mmio && wr_any && (wr_off == OFF_MTCMP_HI);
    assign ctrl_wr     = wr_mmio && wr_any && (wr_off == OFF_CTRL);

    assign irq_set = en_reg && (mtime_reg >= mtcmp_reg);
    assign irq_clr = ctrl_wr && ram_wr_en_i[0] && ram_wr_data_i[1];

    always_comb begin
        gpio_next  = gpio_reg;
        mtcmp_next = mtcmp_reg;
        mtime_next = mtime_reg;
        en_next    = en_reg;

        if (gpio_wr) begin
            gpio_next = merge_bytes(gpio_reg, ram_wr_data_i, ram_wr_en_i);
        end
        if (mtcmp_lo_wr) begin
            mtcmp_next[31:0] = merge_bytes(mtcmp_reg[31:0], ram_wr_data_i, ram_wr_en_i);
        end
        if (mtcmp_hi_wr) begin
            mtcmp_next[63:32] = merge_bytes(mtcmp_reg[63:32], ram_wr_data_i, ram_wr_en_i);
        end

        // A software write to either half suppresses the increment for that
        // cycle; the untouched half keeps its pre-increment value.
        if (mtime_lo_wr) begin
            mtime_next[31:0] = merge_bytes(mtime_reg[31:0], ram_wr_data_i, ram_wr_en_i);
        end else if (mtime_hi_wr) begin
            mtime_next[63:32] = merge_bytes(mtime_reg[63:32], ram_wr_data_i, ram_wr_en_i);
        end else if (en_reg) begin
            mtime_next = mtime_reg + 64'd1;
        end

        if (ctrl_wr && ram_wr_en_i[0]) begin
            en_next = ram_wr_data_i[0];
        end

        // Sticky pending bit; a new set condition beats a same-edge clear.
        irq_next = irq_set | (irq_reg & ~irq_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_reg  <= '0;
            mtime_reg <= '0;
            mtcmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_reg    <= 1'b0;
            irq_reg   <= 1'b0;
        end else begin
            gpio_reg  <= gpio_next;
            mtime_reg <= mtime_next;
            mtcmp_reg <= mtcmp_next;
            en_reg    <= en_next;
            irq_reg   <= irq_next;
        end
    end

    // ------------------------------------------------------------------
    // Read path: MMIO value and source select are captured at the edge
    // (from pre-edge register values, hence read-first), then muxed.
    // ------------------------------------------------------------------
    logic [31:0] mmio_rd_next, mmio_q_reg;
    rd_sel_t     rd_sel_next, rd_sel_reg;

    always_comb begin
        mmio_rd_next = '0;
        case (rd_off)
            OFF_GPIO:     mmio_rd_next = gpio_reg;
            OFF_MTIME_LO: mmio_rd_next = mtime_reg[31:0];
            OFF_MTIME_HI: mmio_rd_next = mtime_reg[63:32];
            OFF_MTCMP_LO: mmio_rd_next = mtcmp_reg[31:0];
            OFF_MTCMP_HI: mmio_rd_next = mtcmp_reg[63:32];
            OFF_CTRL:     mmio_rd_next = {30'd0, irq_reg, en_reg};
            default:      mmio_rd_next = '0;
        endcase
    end

    always_comb begin
        rd_sel_next = SEL_NONE;
        if (rd_mmio) begin
            rd_sel_next = SEL_MMIO;
        end else if (rd_ram) begin
            rd_sel_next = SEL_RAM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmio_q_reg <= '0;
            rd_sel_reg <= SEL_NONE;
        end else begin
            mmio_q_reg <= mmio_rd_next;
            rd_sel_reg <= rd_sel_next;
        end
    end

    always_comb begin
        ram_rd_data_o = '0;
        case (rd_sel_reg)
            SEL_RAM:  ram_rd_data_o = ram_q_reg;
            SEL_MMIO: ram_rd_data_o = mmio_q_reg;
            default:  ram_rd_data_o = '0;
        endcase
    end

    assign gpio_o      = gpio_reg;
    assign timer_irq_o = irq_reg;

endmodule
